// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store unit controller between the MEM stage and the
//                data-memory port. Checks alignment, builds word address,
//                byte enables and lane-replicated store data, runs a
//                valid/ready handshake with a bounded wait, and returns
//                lane-shifted, sign/zero-extended load data.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        exc_misaligned,
  output logic        exc_timeout,
  output logic        dmem_valid,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last BUSY cycle index before the wait is abandoned.
  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        dmem_valid_q, dmem_valid_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        exc_mis_q, exc_mis_d;
  logic        exc_tmo_q, exc_tmo_d;

  logic        w_illegal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  // Decode the incoming request: legality, byte enables and replicated store data.
  always_comb begin
    w_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: w_illegal = 1'b0;
      3'b001, 3'b101: w_illegal = req_addr[0];
      3'b010:         w_illegal = (req_addr[1:0] != 2'b00);
      default:        w_illegal = 1'b1;
    endcase
    // Unsigned widths have no store form.
    if (req_we && req_funct3[2]) w_illegal = 1'b1;

    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Shift the addressed lane down and extend it from the lane's own MSB.
  always_comb begin
    w_lane = dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = w_lane;
    endcase
  end

  // Next-state and next-output logic for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    dmem_valid_d = dmem_valid_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    exc_mis_d    = 1'b0;
    exc_tmo_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (w_illegal) begin
            state_d     = S_DONE;
            rsp_valid_d = 1'b1;
            exc_mis_d   = 1'b1;
            rsp_data_d  = 32'd0;
          end else begin
            state_d      = S_BUSY;
            cnt_d        = 8'd0;
            off_d        = req_addr[1:0];
            funct3_d     = req_funct3;
            dmem_valid_d = 1'b1;
            dmem_we_d    = req_we;
            dmem_addr_d  = {req_addr[31:2], 2'b00};
            dmem_be_d    = w_be;
            dmem_wdata_d = w_wdata;
          end
        end
      end
      S_BUSY: begin
        if (dmem_ready) begin
          state_d      = S_DONE;
          dmem_valid_d = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = dmem_we_q ? 32'd0 : w_ext;
        end else if (cnt_q == c_cnt_last) begin
          state_d      = S_DONE;
          dmem_valid_d = 1'b0;
          rsp_valid_d  = 1'b1;
          exc_tmo_d    = 1'b1;
          rsp_data_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      off_q        <= 2'd0;
      funct3_q     <= 3'd0;
      dmem_valid_q <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'd0;
      dmem_be_q    <= 4'd0;
      dmem_wdata_q <= 32'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      exc_mis_q    <= 1'b0;
      exc_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      dmem_valid_q <= dmem_valid_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      exc_mis_q    <= exc_mis_d;
      exc_tmo_q    <= exc_tmo_d;
    end
  end

  // Stall is held off during reset so the pipeline is never frozen by a dropped access.
  assign stall          = ~reset & (((state_q == S_IDLE) & req_valid) | (state_q == S_BUSY));
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign exc_misaligned = exc_mis_q;
  assign exc_timeout    = exc_tmo_q;
  assign dmem_valid     = dmem_valid_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_be        = dmem_be_q;
  assign dmem_wdata     = dmem_wdata_q;

endmodule
`default_nettype wire
